// File: rtl/regfile_port_scheduler_if.sv
// Bundle of the scheduler's requester, writeback and register-file signals.
// master = surrounding logic (decode, debug, writeback, registers); slave = scheduler.
interface regfile_port_scheduler_if;
  logic        fetch_req;
  logic [4:0]  fetch_rs1;
  logic [4:0]  fetch_rs2;
  logic        fetch_valid;
  logic [31:0] fetch_rs1_value;
  logic [31:0] fetch_rs2_value;
  logic        fetch_ack;
  logic        dbg_req;
  logic [4:0]  dbg_address;
  logic        dbg_valid;
  logic [31:0] dbg_value;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_value;
  logic [4:0]  rf_read_address;
  logic [31:0] rf_read_value;
  logic [4:0]  rf_write_address;
  logic [31:0] rf_write_value;

  modport master (
    output fetch_req, fetch_rs1, fetch_rs2, fetch_ack,
    output dbg_req, dbg_address,
    output wb_valid, wb_rd, wb_value,
    output rf_read_value,
    input  fetch_valid, fetch_rs1_value, fetch_rs2_value,
    input  dbg_valid, dbg_value,
    input  rf_read_address, rf_write_address, rf_write_value
  );

  modport slave (
    input  fetch_req, fetch_rs1, fetch_rs2, fetch_ack,
    input  dbg_req, dbg_address,
    input  wb_valid, wb_rd, wb_value,
    input  rf_read_value,
    output fetch_valid, fetch_rs1_value, fetch_rs2_value,
    output dbg_valid, dbg_value,
    output rf_read_address, rf_write_address, rf_write_value
  );
endinterface

// File: rtl/regfile_port_scheduler.sv
// Shares the single read port of the 32x32 register file between operand fetch
// (rs1 then rs2) and a debug reader; writeback passes straight to the write port.
module regfile_port_scheduler (
  input  logic                     clock,
  input  logic                     reset,
  regfile_port_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH_RS1  = 3'd1,
    S_FETCH_RS2  = 3'd2,
    S_FETCH_HOLD = 3'd3,
    S_DEBUG_READ = 3'd4
  } state_t;

  localparam logic LG_FETCH = 1'b0;
  localparam logic LG_DEBUG = 1'b1;

  state_t      state_q, state_d;
  logic [4:0]  rs1_l_q, rs1_l_d;
  logic [4:0]  rs2_l_q, rs2_l_d;
  logic [4:0]  dbg_l_q, dbg_l_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] dbg_value_q, dbg_value_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        dbg_valid_q, dbg_valid_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_fetch_s;
  logic        grant_dbg_s;
  logic [4:0]  rf_read_address_s;

  // A writeback to a nonzero address this cycle lands in the file at the next edge.
  function automatic logic wb_hit(input logic wb_v, input logic [4:0] wb_a, input logic [4:0] a);
    return wb_v && (wb_a == a) && (a != 5'd0);
  endfunction

  // Value the register will hold after the coming edge.
  function automatic logic [31:0] cap(input logic wb_v, input logic [4:0] wb_a,
                                      input logic [31:0] wb_d, input logic [31:0] rd_d,
                                      input logic [4:0] a);
    return wb_hit(wb_v, wb_a, a) ? wb_d : rd_d;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rs1_l_q       <= 5'd0;
      rs2_l_q       <= 5'd0;
      dbg_l_q       <= 5'd0;
      op1_q         <= 32'd0;
      op2_q         <= 32'd0;
      dbg_value_q   <= 32'd0;
      fetch_valid_q <= 1'b0;
      dbg_valid_q   <= 1'b0;
      last_grant_q  <= LG_DEBUG;
    end else begin
      state_q       <= state_d;
      rs1_l_q       <= rs1_l_d;
      rs2_l_q       <= rs2_l_d;
      dbg_l_q       <= dbg_l_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      dbg_value_q   <= dbg_value_d;
      fetch_valid_q <= fetch_valid_d;
      dbg_valid_q   <= dbg_valid_d;
      last_grant_q  <= last_grant_d;
    end
  end

  // Arbitration and next-state; on a tie the requester not served last wins.
  always_comb begin
    state_d       = state_q;
    grant_fetch_s = 1'b0;
    grant_dbg_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.fetch_req && bus.dbg_req) begin
          if (last_grant_q == LG_DEBUG) begin
            grant_fetch_s = 1'b1;
          end else begin
            grant_dbg_s = 1'b1;
          end
        end else if (bus.fetch_req) begin
          grant_fetch_s = 1'b1;
        end else if (bus.dbg_req) begin
          grant_dbg_s = 1'b1;
        end else begin
          grant_fetch_s = 1'b0;
        end
        if (grant_fetch_s) begin
          state_d = S_FETCH_RS1;
        end else if (grant_dbg_s) begin
          state_d = S_DEBUG_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH_RS1: begin
        if (rs1_l_q == rs2_l_q) begin
          state_d = S_FETCH_HOLD;
        end else begin
          state_d = S_FETCH_RS2;
        end
      end
      S_FETCH_RS2:  state_d = S_FETCH_HOLD;
      S_FETCH_HOLD: begin
        if (bus.fetch_ack) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH_HOLD;
        end
      end
      S_DEBUG_READ: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Read-port steering, operand capture and snooping of held operands.
  always_comb begin
    rs1_l_d           = rs1_l_q;
    rs2_l_d           = rs2_l_q;
    dbg_l_d           = dbg_l_q;
    op1_d             = op1_q;
    op2_d             = op2_q;
    dbg_value_d       = dbg_value_q;
    last_grant_d      = last_grant_q;
    rf_read_address_s = 5'd0;
    case (state_q)
      S_IDLE: begin
        if (grant_fetch_s) begin
          rs1_l_d      = bus.fetch_rs1;
          rs2_l_d      = bus.fetch_rs2;
          last_grant_d = LG_FETCH;
        end else if (grant_dbg_s) begin
          dbg_l_d      = bus.dbg_address;
          last_grant_d = LG_DEBUG;
        end else begin
          last_grant_d = last_grant_q;
        end
      end
      S_FETCH_RS1: begin
        rf_read_address_s = rs1_l_q;
        op1_d = cap(bus.wb_valid, bus.wb_rd, bus.wb_value, bus.rf_read_value, rs1_l_q);
        if (rs1_l_q == rs2_l_q) begin
          op2_d = cap(bus.wb_valid, bus.wb_rd, bus.wb_value, bus.rf_read_value, rs1_l_q);
        end else begin
          op2_d = op2_q;
        end
      end
      S_FETCH_RS2: begin
        rf_read_address_s = rs2_l_q;
        op2_d = cap(bus.wb_valid, bus.wb_rd, bus.wb_value, bus.rf_read_value, rs2_l_q);
        if (wb_hit(bus.wb_valid, bus.wb_rd, rs1_l_q)) begin
          op1_d = bus.wb_value;
        end else begin
          op1_d = op1_q;
        end
      end
      S_FETCH_HOLD: begin
        if (wb_hit(bus.wb_valid, bus.wb_rd, rs1_l_q)) begin
          op1_d = bus.wb_value;
        end else begin
          op1_d = op1_q;
        end
        if (wb_hit(bus.wb_valid, bus.wb_rd, rs2_l_q)) begin
          op2_d = bus.wb_value;
        end else begin
          op2_d = op2_q;
        end
      end
      S_DEBUG_READ: begin
        rf_read_address_s = dbg_l_q;
        dbg_value_d = cap(bus.wb_valid, bus.wb_rd, bus.wb_value, bus.rf_read_value, dbg_l_q);
      end
      default: rf_read_address_s = 5'd0;
    endcase
    fetch_valid_d = (state_d == S_FETCH_HOLD);
    dbg_valid_d   = (state_q == S_DEBUG_READ);
  end

  assign bus.fetch_valid      = fetch_valid_q;
  assign bus.fetch_rs1_value  = op1_q;
  assign bus.fetch_rs2_value  = op2_q;
  assign bus.dbg_valid        = dbg_valid_q;
  assign bus.dbg_value        = dbg_value_q;
  assign bus.rf_read_address  = rf_read_address_s;
  assign bus.rf_write_address = bus.wb_valid ? bus.wb_rd : 5'd0;
  assign bus.rf_write_value   = bus.wb_value;

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Directed plus randomized bench: operands must always equal current register
// contents, and latency/arbitration follow the transaction-level rules.
module tb_regfile_port_scheduler;
  logic clock;
  logic reset;
  regfile_port_scheduler_if bus ();

  regfile_port_scheduler dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file fed by the DUT's write port, read combinationally.
  logic [31:0] mem [32];
  always @(posedge clock) begin
    if (bus.rf_write_address != 5'd0) mem[bus.rf_write_address] <= bus.rf_write_value;
  end
  assign bus.rf_read_value = (bus.rf_read_address == 5'd0) ? 32'd0 : mem[bus.rf_read_address];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_rf [32];
  logic [4:0]  f_rs1, f_rs2, d_addr;
  bit          rand_wb;
  bit          last_dbg;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Sample at negedge; check write pass-through and coherence of any valid result.
  task automatic sample();
    @(negedge clock);
    check32("wr_addr", {27'd0, bus.rf_write_address}, bus.wb_valid ? {27'd0, bus.wb_rd} : 32'd0);
    check32("wr_data", bus.rf_write_value, bus.wb_value);
    if (bus.fetch_valid) begin
      check32("rs1_value", bus.fetch_rs1_value, ref_rf[f_rs1]);
      check32("rs2_value", bus.fetch_rs2_value, ref_rf[f_rs2]);
      check32("hold_rd_addr", {27'd0, bus.rf_read_address}, 32'd0);
    end
    if (bus.dbg_valid) check32("dbg_value", bus.dbg_value, ref_rf[d_addr]);
  endtask

  task automatic edge_();
    int r;
    @(posedge clock);
    if (bus.wb_valid && bus.wb_rd != 5'd0) ref_rf[bus.wb_rd] = bus.wb_value;
    #1;
    if (rand_wb) begin
      r = $urandom_range(0, 3);
      bus.wb_valid = ($urandom_range(0, 1) == 1);
      bus.wb_rd    = (r == 0) ? f_rs1 : (r == 1) ? f_rs2 : (r == 2) ? d_addr : 5'($urandom_range(0, 31));
      bus.wb_value = $urandom;
    end
  endtask

  task automatic fetch_txn(input logic [4:0] rs1, input logic [4:0] rs2, input int exp_lat,
                           input int wb_cyc, input logic [4:0] wr, input logic [31:0] wv,
                           input int hold);
    int cyc;
    bit got;
    f_rs1 = rs1; f_rs2 = rs2;
    bus.fetch_rs1 = rs1; bus.fetch_rs2 = rs2; bus.fetch_req = 1'b1;
    cyc = 0; got = 1'b0;
    while (cyc < 20) begin
      if (wb_cyc >= 0) begin
        bus.wb_valid = (cyc == wb_cyc); bus.wb_rd = wr; bus.wb_value = wv;
      end
      sample();
      if (bus.fetch_valid) begin got = 1'b1; break; end
      edge_();
      cyc++;
    end
    check32("fetch_lat", 32'(cyc), 32'(exp_lat));
    for (int h = 0; h < hold; h++) begin
      edge_();
      cyc++;
      if (wb_cyc >= 0) begin
        bus.wb_valid = (cyc == wb_cyc); bus.wb_rd = wr; bus.wb_value = wv;
      end
      sample();
      check32("fetch_valid_hold", {31'd0, bus.fetch_valid}, 32'd1);
    end
    bus.fetch_ack = 1'b1; bus.fetch_req = 1'b0;
    edge_();
    bus.fetch_ack = 1'b0;
    if (wb_cyc >= 0) bus.wb_valid = 1'b0;
    sample();
    check32("fetch_valid_after_ack", {31'd0, bus.fetch_valid}, 32'd0);
    edge_();
  endtask

  task automatic dbg_txn(input logic [4:0] a, input int exp_lat);
    int cyc;
    d_addr = a; bus.dbg_address = a; bus.dbg_req = 1'b1;
    cyc = 0;
    while (cyc < 20) begin
      sample();
      if (bus.dbg_valid) break;
      edge_();
      cyc++;
    end
    check32("dbg_lat", 32'(cyc), 32'(exp_lat));
    bus.dbg_req = 1'b0;
    edge_();
    sample();
    check32("dbg_valid_pulse", {31'd0, bus.dbg_valid}, 32'd0);
    edge_();
  endtask

  initial begin
    logic [4:0] a, b, c;
    bus.fetch_req = 1'b0; bus.fetch_rs1 = 5'd0; bus.fetch_rs2 = 5'd0; bus.fetch_ack = 1'b0;
    bus.dbg_req = 1'b0; bus.dbg_address = 5'd0;
    bus.wb_valid = 1'b0; bus.wb_rd = 5'd0; bus.wb_value = 32'd0;
    f_rs1 = 5'd0; f_rs2 = 5'd0; d_addr = 5'd0; rand_wb = 1'b0; last_dbg = 1'b1;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    reset = 1'b1;

    // Reset state, with writeback passing through while in reset.
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd7; bus.wb_value = 32'h0000_0077;
    sample();
    check32("rst_fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
    check32("rst_dbg_valid", {31'd0, bus.dbg_valid}, 32'd0);
    check32("rst_rs1", bus.fetch_rs1_value, 32'd0);
    check32("rst_rs2", bus.fetch_rs2_value, 32'd0);
    check32("rst_dbg_value", bus.dbg_value, 32'd0);
    check32("rst_rd_addr", {27'd0, bus.rf_read_address}, 32'd0);
    edge_();
    reset = 1'b0;

    // Preload every register through the write path.
    for (int i = 1; i < 32; i++) begin
      bus.wb_valid = 1'b1; bus.wb_rd = 5'(i);
      bus.wb_value = (i == 2) ? 32'd2 : (i == 5) ? 32'd7 : (i == 3) ? 32'h33 : $urandom;
      sample();
      edge_();
    end
    bus.wb_rd = 5'd0; bus.wb_value = 32'hFF;
    sample();
    edge_();
    bus.wb_valid = 1'b0;

    // First tie after reset: fetch, then debug.
    d_addr = 5'd2; bus.dbg_address = 5'd2; bus.dbg_req = 1'b1;
    fetch_txn(5'd2, 5'd5, 3, -1, 5'd0, 32'd0, 1);
    dbg_txn(5'd2, 1);
    check32("dbg_x2", bus.dbg_value, 32'd2);

    // Forward into rs2 during FETCH_RS2.
    fetch_txn(5'd2, 5'd5, 3, 2, 5'd5, 32'h55, 0);
    check32("fwd_rs2", bus.fetch_rs2_value, 32'h55);

    // Tie after a fetch: debug first, then fetch with a snoop in hold.
    f_rs1 = 5'd2; f_rs2 = 5'd5; bus.fetch_rs1 = 5'd2; bus.fetch_rs2 = 5'd5; bus.fetch_req = 1'b1;
    dbg_txn(5'd3, 2);
    fetch_txn(5'd2, 5'd5, 1, 1, 5'd2, 32'h22, 2);
    check32("snoop_rs1", bus.fetch_rs1_value, 32'h22);

    // x0 with a writeback to x0 in the same cycle, then equal addresses.
    fetch_txn(5'd0, 5'd0, 2, 1, 5'd0, 32'hFF, 0);
    check32("x0_rs1", bus.fetch_rs1_value, 32'd0);
    fetch_txn(5'd3, 5'd3, 2, -1, 5'd0, 32'd0, 1);
    check32("eq_rs2", bus.fetch_rs2_value, 32'h33);

    // Reset while in FETCH_RS2.
    f_rs1 = 5'd2; f_rs2 = 5'd5; bus.fetch_rs1 = 5'd2; bus.fetch_rs2 = 5'd5; bus.fetch_req = 1'b1;
    edge_();
    edge_();
    reset = 1'b1;
    bus.fetch_req = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd9; bus.wb_value = 32'h9999;
    #1;
    check32("midrst_fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
    check32("midrst_rd_addr", {27'd0, bus.rf_read_address}, 32'd0);
    check32("midrst_rs1", bus.fetch_rs1_value, 32'd0);
    check32("midrst_rs2", bus.fetch_rs2_value, 32'd0);
    check32("midrst_dbg_value", bus.dbg_value, 32'd0);
    check32("midrst_wr_addr", {27'd0, bus.rf_write_address}, 32'd9);
    edge_();
    reset = 1'b0;
    bus.wb_valid = 1'b0;
    last_dbg = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample();
      check32("midrst_no_valid", {31'd0, bus.fetch_valid}, 32'd0);
      edge_();
    end

    // Randomized transactions with random writeback traffic.
    rand_wb = 1'b1;
    for (int it = 0; it < 60; it++) begin
      a = 5'($urandom_range(0, 31));
      b = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      c = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 2))
        0: begin
          fetch_txn(a, b, (a == b) ? 2 : 3, -1, 5'd0, 32'd0, $urandom_range(0, 3));
          last_dbg = 1'b0;
        end
        1: begin
          dbg_txn(c, 2);
          last_dbg = 1'b1;
        end
        default: begin
          if (last_dbg) begin
            d_addr = c; bus.dbg_address = c; bus.dbg_req = 1'b1;
            fetch_txn(a, b, (a == b) ? 2 : 3, -1, 5'd0, 32'd0, $urandom_range(0, 3));
            dbg_txn(c, 1);
            last_dbg = 1'b1;
          end else begin
            f_rs1 = a; f_rs2 = b; bus.fetch_rs1 = a; bus.fetch_rs2 = b; bus.fetch_req = 1'b1;
            dbg_txn(c, 2);
            fetch_txn(a, b, (a == b) ? 0 : 1, -1, 5'd0, 32'd0, $urandom_range(0, 3));
            last_dbg = 1'b0;
          end
        end
      endcase
    end
    rand_wb = 1'b0;
    bus.wb_valid = 1'b0;
    edge_();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
